// File: rtl/debug_dump_pkg.sv
// Shared constants for the debug dump collector: command bytes, command codes,
// FSM states, frame geometry and dump field offsets.
package debug_dump_pkg;

  localparam int FRAME_BYTES = 95;

  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_NEXT = 8'h6E;

  typedef enum logic [1:0] {
    CODE_CONT = 2'd0,
    CODE_STEP = 2'd1,
    CODE_NEXT = 2'd2,
    CODE_RSVD = 2'd3
  } cmd_code_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_CMD = 2'd1,
    ST_COLLECT  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int OFF_PC          = 0;
  localparam int OFF_INSTR       = 1;
  localparam int OFF_IDEX_SIGEXT = 7;
  localparam int OFF_REGS0       = 55;
  localparam int OFF_RAM0        = 75;

  function automatic logic [7:0] cmdByte(input cmd_code_t code);
    case (code)
      CODE_CONT: cmdByte = CMD_CONT;
      CODE_STEP: cmdByte = CMD_STEP;
      CODE_NEXT: cmdByte = CMD_NEXT;
      default:   cmdByte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/debug_dump_collector_if.sv
// Command, UART TX FIFO and UART RX FIFO signals of the dump collector.
// master = host/harness side, slave = collector side.
interface debug_dump_collector_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_read;

  modport master (
    output cmd_valid, cmd_code, tx_full, rx_data, rx_available,
    input  cmd_ready, tx_data, tx_write, rx_read
  );

  modport slave (
    input  cmd_valid, cmd_code, tx_full, rx_data, rx_available,
    output cmd_ready, tx_data, tx_write, rx_read
  );
endinterface

// File: rtl/dump_frame_buffer.sv
// FRAME_BYTES x 8 frame store: synchronous write, combinational read,
// reads beyond the frame return 0. No backpressure.
module dump_frame_buffer
  import debug_dump_pkg::*;
(
  input  logic       clock,
  input  logic       wrEn,
  input  logic [6:0] wrAddr,
  input  logic [7:0] wrData,
  input  logic [6:0] rdAddr,
  output logic [7:0] rdData
);

  logic [7:0] mem [FRAME_BYTES];

  always_ff @(posedge clock) begin
    if (wrEn && (wrAddr < 7'(FRAME_BYTES))) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = (rdAddr < 7'(FRAME_BYTES)) ? mem[rdAddr] : 8'h00;

endmodule

// File: rtl/debug_dump_collector.sv
// Sends 'c'/'s'/'n' to the UART TX FIFO and collects the 95-byte dump frame; waits on tx_full,
// frame_done one cycle after the last byte is stored. DUMP_FIELD_DECODE_EN adds dbg_pc/dbg_instr.
module debug_dump_collector
  import debug_dump_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  debug_dump_collector_if.slave  bus,
  input  logic [6:0]             rd_addr,
  output logic [7:0]             rd_data,
  output logic                   frame_done,
  output logic [7:0]             frame_count,
  output logic                   busy,
  output logic                   timeout_err
`ifdef DUMP_FIELD_DECODE_EN
  ,
  output logic [7:0]             dbg_pc,
  output logic [31:0]            dbg_instr
`endif
);

  state_t           state, stateNext;
  cmd_code_t        cmdCode;
  logic [6:0]       byteIdx;
  logic [CNT_W-1:0] toCnt;
  logic [7:0]       frameCount;
  logic             timeoutErr;
  logic             cmdAccept;
  logic             bufWrEn;
  logic             lastByte;
  logic             toExpire;

  assign cmdAccept = (state == ST_IDLE) && bus.cmd_valid && (cmd_code_t'(bus.cmd_code) != CODE_RSVD);
  assign bufWrEn   = (state == ST_COLLECT) && bus.rx_available && !reset;
  assign lastByte  = (byteIdx == 7'(FRAME_BYTES - 1));
  assign toExpire  = (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Handshake outputs are held low while reset is asserted so nothing is popped or written.
  always_comb begin
    stateNext     = state;
    bus.cmd_ready = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_write  = 1'b0;
    bus.rx_read   = 1'b0;
    frame_done    = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          bus.cmd_ready = 1'b1;
          bus.rx_read   = bus.rx_available;
          if (cmdAccept) stateNext = ST_SEND_CMD;
        end
        ST_SEND_CMD: begin
          bus.tx_data  = cmdByte(cmdCode);
          bus.tx_write = !bus.tx_full;
          if (!bus.tx_full) stateNext = (cmdCode == CODE_STEP) ? ST_IDLE : ST_COLLECT;
        end
        ST_COLLECT: begin
          bus.rx_read = bus.rx_available;
          if (bus.rx_available && lastByte)      stateNext = ST_DONE;
          else if (!bus.rx_available && toExpire) stateNext = ST_IDLE;
        end
        ST_DONE: begin
          frame_done = 1'b1;
          stateNext  = ST_IDLE;
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmdCode    <= CODE_CONT;
      byteIdx    <= '0;
      toCnt      <= '0;
      frameCount <= '0;
      timeoutErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmdAccept) begin
            cmdCode    <= cmd_code_t'(bus.cmd_code);
            timeoutErr <= 1'b0;
          end
        end
        ST_SEND_CMD: begin
          if (!bus.tx_full) begin
            byteIdx <= '0;
            toCnt   <= '0;
          end
        end
        ST_COLLECT: begin
          if (bus.rx_available) begin
            byteIdx <= byteIdx + 7'd1;
            toCnt   <= '0;
          end else if (toExpire) begin
            timeoutErr <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        ST_DONE: frameCount <= frameCount + 8'd1;
        default: ;
      endcase
    end
  end

  dump_frame_buffer u_buf (
    .clock  (clock),
    .wrEn   (bufWrEn),
    .wrAddr (byteIdx),
    .wrData (bus.rx_data),
    .rdAddr (rd_addr),
    .rdData (rd_data)
  );

  assign frame_count = frameCount;
  assign timeout_err = timeoutErr;
  assign busy        = (state != ST_IDLE);

`ifdef DUMP_FIELD_DECODE_EN
  // Header bytes shift in as they arrive so byte 0 ends up in the top octet.
  logic [39:0] hdrShadow;

  always_ff @(posedge clock) begin
    if (reset) begin
      hdrShadow <= '0;
      dbg_pc    <= '0;
      dbg_instr <= '0;
    end else begin
      if (bufWrEn && (byteIdx < 7'(OFF_INSTR + 4))) hdrShadow <= {hdrShadow[31:0], bus.rx_data};
      if (state == ST_DONE) begin
        dbg_pc    <= hdrShadow[39:32];
        dbg_instr <= hdrShadow[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_debug_dump_collector.sv
// Scoreboard bench for debug_dump_collector: expected TX bytes and frame completions are queued
// by the stimulus and popped by independent monitors when the DUT presents them.
module tb_debug_dump_collector;
  import debug_dump_pkg::*;

  localparam int TO_CYC = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        busy;
  logic        timeout_err;
`ifdef DUMP_FIELD_DECODE_EN
  logic [7:0]  dbg_pc;
  logic [31:0] dbg_instr;
`endif

  debug_dump_collector_if bus();

  debug_dump_collector #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(20)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef DUMP_FIELD_DECODE_EN
    ,
    .dbg_pc      (dbg_pc),
    .dbg_instr   (dbg_instr)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  count;
    logic [7:0]  pc;
    logic [31:0] instr;
  } done_exp_t;

  int         nCmp = 0;
  int         nBad = 0;
  int         cyc = 0;
  int         popCount = 0;
  int         lastPopCyc = 0;
  bit         popPending = 1'b0;
  logic [7:0] rxFifo[$];
  logic [7:0] txQ[$];
  done_exp_t  doneQ[$];
  done_exp_t  curExp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // RX FIFO model: pop decision sampled mid-cycle, applied just after the edge.
  always @(negedge clock) begin
    popPending = bus.rx_read;
    if (bus.rx_read) begin
      popCount++;
      lastPopCyc = cyc + 1;
    end
  end

  always @(posedge clock) begin
    #1;
    if (popPending && rxFifo.size() != 0) void'(rxFifo.pop_front());
    bus.rx_available = (rxFifo.size() != 0);
    if (rxFifo.size() != 0) bus.rx_data = rxFifo[0];
    else                    bus.rx_data = 8'h00;
  end

  always @(negedge clock) begin
    if (bus.tx_write) begin
      if (txQ.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL tx_unexpected: got write 0x%0h, want none", bus.tx_data);
      end else begin
        check("tx_data", 32'(bus.tx_data), 32'(txQ.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    if (frame_done) begin
      if (doneQ.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL frame_done_unexpected: got pulse at cycle %0d, want none", cyc);
      end else begin
        curExp = doneQ.pop_front();
        @(posedge clock);
        #1;
        check("frame_count", 32'(frame_count), 32'(curExp.count));
`ifdef DUMP_FIELD_DECODE_EN
        check("dbg_pc", 32'(dbg_pc), 32'(curExp.pc));
        check("dbg_instr", dbg_instr, curExp.instr);
`endif
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic issue(input logic [1:0] code, input logic [7:0] expByte);
    int k = 0;
    while (!bus.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    if (code != 2'd3) txQ.push_back(expByte);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'd0;
  endtask

  task automatic waitTx();
    int k = 0;
    while (txQ.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check("tx_pending", 32'(txQ.size()), 32'd0);
    txQ.delete();
  endtask

  task automatic sendBytes(input int n, input logic [7:0] base, input bit gaps);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      rxFifo.push_back(base + 8'(i));
      tick(1 + (gaps ? (i % 4) : 0));
    end
    while (rxFifo.size() != 0 && k < 50) begin
      tick();
      k++;
    end
  endtask

  task automatic waitDone();
    int k = 0;
    while (doneQ.size() != 0 && k < 2000) begin
      tick();
      k++;
    end
    if (doneQ.size() != 0) begin
      nCmp++;
      nBad++;
      $display("FAIL frame_done_timeout: got no pulse, want frame_done within 2000 cycles");
      doneQ.delete();
    end
    tick(2);
  endtask

  task automatic rdCheck(input string name, input logic [6:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_tx_write"}, 32'(bus.tx_write), 32'd0);
    check({tag, "_rx_read"}, 32'(bus.rx_read), 32'd0);
`ifdef DUMP_FIELD_DECODE_EN
    check({tag, "_dbg_pc"}, 32'(dbg_pc), 32'd0);
    check({tag, "_dbg_instr"}, dbg_instr, 32'd0);
`endif
  endtask

  initial begin
    int p0;
    int bad;
    int k;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'd0;
    bus.tx_full   = 1'b0;

    // Reset state
    reset = 1'b1;
    tick(3);
    checkResetOutputs("rst");
    reset = 1'b0;
    tick();
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Reserved code is ignored
    issue(2'd3, 8'h00);
    tick(3);
    check("rsvd_busy", 32'(busy), 32'd0);

    // Step-arm: one write of 's', straight back to IDLE, nothing popped
    p0 = popCount;
    issue(2'd1, CMD_STEP);
    check("step_busy_send", 32'(busy), 32'd1);
    tick();
    check("step_busy_after", 32'(busy), 32'd0);
    check("step_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("step_tx_count", 32'(txQ.size()), 32'd0);
    check("step_no_rx_read", 32'(popCount - p0), 32'd0);

    // Next: full frame 0x00..0x5E with 0-3 cycle gaps
    issue(2'd2, CMD_NEXT);
    doneQ.push_back('{count: 8'd1, pc: 8'h00, instr: 32'h01020304});
    sendBytes(FRAME_BYTES, 8'h00, 1'b1);
    waitDone();
    check("n_frame_busy", 32'(busy), 32'd0);
    rdCheck("rd_42", 7'd42, 8'h2A);
    rdCheck("rd_94", 7'd94, 8'h5E);
    rdCheck("rd_95_oob", 7'd95, 8'h00);

    // Continuous with tx_full held, then 40 bytes and silence
    bus.tx_full = 1'b1;
    issue(2'd0, CMD_CONT);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_write) bad++;
      tick();
    end
    check("txfull_write_held", 32'(bad), 32'd0);
    check("txfull_busy", 32'(busy), 32'd1);
    bus.tx_full = 1'b0;
    waitTx();
    sendBytes(40, 8'h10, 1'b0);
    k = 0;
    while (!timeout_err && k < 300) begin
      @(negedge clock);
      k++;
    end
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("timeout_delay", 32'(cyc - lastPopCyc), 32'(TO_CYC));
    tick();
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_frame_count", 32'(frame_count), 32'd1);
    rdCheck("partial_39", 7'd39, 8'h37);
    rdCheck("partial_40_old", 7'd40, 8'h28);
    issue(2'd1, CMD_STEP);
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);
    waitTx();

    // Stray bytes in IDLE are drained; next frame aligns at address 0
    p0 = popCount;
    rxFifo.push_back(8'hAA);
    rxFifo.push_back(8'hBB);
    rxFifo.push_back(8'hCC);
    tick(6);
    check("stray_drained", 32'(popCount - p0), 32'd3);
    check("stray_fifo_empty", 32'(bus.rx_available), 32'd0);
    issue(2'd2, CMD_NEXT);
    doneQ.push_back('{count: 8'd2, pc: 8'h80, instr: 32'h81828384});
    sendBytes(FRAME_BYTES, 8'h80, 1'b1);
    waitDone();
    rdCheck("stray_rd_0", 7'd0, 8'h80);
    rdCheck("stray_rd_94", 7'd94, 8'hDE);
    rdCheck("rd_127_oob", 7'd127, 8'h00);

    // Reset at byte 50, then a clean frame
    issue(2'd2, CMD_NEXT);
    p0 = popCount;
    sendBytes(50, 8'h40, 1'b0);
    check("midreset_bytes", 32'(popCount - p0), 32'd50);
    reset = 1'b1;
    tick();
    checkResetOutputs("midrst");
    reset = 1'b0;
    tick();
    issue(2'd2, CMD_NEXT);
    doneQ.push_back('{count: 8'd1, pc: 8'h00, instr: 32'h01020304});
    sendBytes(FRAME_BYTES, 8'h00, 1'b1);
    waitDone();
    rdCheck("post_reset_rd_50", 7'd50, 8'h32);
    check("tx_queue_empty", 32'(txQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/debug_dump_collector.md
Name: debug_dump_collector

Overview:
- Host-side counterpart of the pipeline debug unit. It issues the single-byte ASCII commands 'c', 's' and 'n' into a UART TX FIFO.
- It collects the 95-byte pipeline/register/RAM dump frame returned through a UART RX FIFO and stores it in a byte-addressable buffer.
- It sits between a board-to-board UART link (or loopback test harness) and local checking logic.

Parameters:
- FRAME_BYTES, 95, dump frame length in bytes; byte 0 is sent first.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between frame bytes before abort.
- CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_code  in  2  0='c' continuous, 1='s' step-arm, 2='n' next, 3=reserved
- cmd_ready  out  1  high only in IDLE
- tx_data  out  8  command byte to TX FIFO
- tx_write  out  1  TX FIFO write strobe
- tx_full  in  1  TX FIFO full
- rx_data  in  8  RX FIFO head byte, valid while rx_available
- rx_available  in  1  RX FIFO not empty
- rx_read  out  1  pop RX FIFO; the byte is consumed on the same edge
- rd_addr  in  7  buffer read address
- rd_data  out  8  buffer byte at rd_addr, combinational; 0 if rd_addr >= FRAME_BYTES
- frame_done  out  1  one-cycle pulse when a full frame is stored
- frame_count  out  8  completed frames, wraps 255->0
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky frame-abort flag
- dbg_pc  out  8  present only with DUMP_FIELD_DECODE_EN
- dbg_instr  out  32  present only with DUMP_FIELD_DECODE_EN

Behaviour:
- Reset values: state IDLE; tx_write, rx_read, frame_done, timeout_err, frame_count, byte index and timeout counter all 0. Buffer contents are not cleared.
- States: IDLE, SEND_CMD, COLLECT, DONE.
- IDLE:
  - cmd_ready=1.
  - cmd_valid with code 0/1/2: latch the code and go to SEND_CMD; timeout_err clears on that edge.
  - code 3: ignored, stay in IDLE.
  - rx_read = rx_available, so stray bytes are drained and discarded to keep frames aligned. If cmd_valid and rx_available occur together, the drain still happens that cycle.
- SEND_CMD:
  - tx_data = "c"/"s"/"n".
  - tx_write=1 only while !tx_full; wait indefinitely while full.
  - On the write edge: code 's' goes to IDLE (the debug unit sends no frame for 's'). Codes 'c' and 'n' go to COLLECT with index=0 and timeout counter=0.
- COLLECT:
  - rx_read = rx_available. Each popped byte is written to buffer[index], index increments, and the timeout counter resets.
  - With no byte, the timeout counter increments. On reaching TIMEOUT_CYCLES: timeout_err=1, go to IDLE, no frame_done, partial data is left in the buffer.
  - When the byte at index FRAME_BYTES-1 is written, go to DONE.
- DONE:
  - frame_done=1 for exactly one cycle.
  - frame_count increments.
  - rx_read=0.
  - Next state IDLE.
- Latency: frame_done asserts the cycle after the edge that stores the last byte.
- Reset mid-COLLECT aborts the frame with no frame_done; the next frame refills from index 0.
- Illegal state encoding goes to IDLE.
- 'c' frames arrive only after the program ends; TIMEOUT_CYCLES must be sized for that, or software re-issues.

Optional Feature:
- DUMP_FIELD_DECODE_EN defined:
  - dbg_pc holds byte0 and dbg_instr holds {byte1,byte2,byte3,byte4}, big-endian.
  - Both register on the DONE cycle and hold until the next DONE. Reset value is 0.
- Undefined: both ports and their registers are absent; behaviour is otherwise identical.

Decomposition:
- Package debug_dump_pkg:
  - command byte constants CMD_CONT=8'h63, CMD_STEP=8'h73, CMD_NEXT=8'h6E;
  - cmd_code encodings;
  - state enum;
  - FRAME_BYTES;
  - field offsets: PC=0, INSTR=1, IDEX_SIGEXT=7, REGS0=55, RAM0=75.
- Sub-module dump_frame_buffer: FRAME_BYTES x 8, synchronous write, asynchronous read, out-of-range read returns 0.

Test Plan:
- Code 1 ('s') with tx_full=0: exactly one tx_write with tx_data=8'h73, back in IDLE the next cycle, no rx_read.
- Code 2 ('n'), then 95 bytes 0x00..0x5E with gaps of 0-3 cycles: one frame_done, frame_count=1, rd_addr=42 returns 0x2A. With the macro: dbg_pc=0x00, dbg_instr=0x01020304.
- tx_full held high for 10 cycles after code 0: tx_write stays 0 during that time, then writes 8'h63 once tx_full drops.
- 40 bytes then silence with TIMEOUT_CYCLES=100: timeout_err=1 at cycle 100 after the last byte, no frame_done, busy=0. A following command clears timeout_err.
- 3 stray bytes in IDLE: all drained, and the subsequent 'n' frame stores the first post-command byte at address 0.
- Reset asserted at byte 50: all outputs 0. A new 'n' frame completes with frame_count=1.
